// File: rtl/mem_dump_uart.sv
// ---------------------------------------------------------------------------
// mem_dump_uart
//
// Purpose: reads a contiguous range of the 21-bit external address space and
// sends each byte out as a UART 8N1 frame. After the last data byte it sends
// one more frame carrying the 8-bit sum (mod 256) of all bytes sent. This is
// the read-back counterpart of the program loader.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..1023)
//   RD_LAT        clk cycles from read asserted to din valid (1..7)
//
// Ports:
//   clk        block clock, rising edge
//   n_reset    asynchronous active-low reset
//   start      dump request, honoured only when idle and not pending
//   start_adr  first byte address, captured on an accepted start
//   len        byte count minus one, captured on an accepted start
//   hold       host flow control; while high no new frame is begun
//   busy       high from accepted start until the checksum frame is done
//   done       one-cycle pulse after the checksum frame
//   adr        memory address
//   read       memory read strobe, one cycle per byte
//   din        memory read data
//   tx         UART serial output, idle high
// ---------------------------------------------------------------------------
module mem_dump_uart #(
  parameter int CLKS_PER_BIT = 36,
  parameter int RD_LAT       = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [20:0] start_adr,
  input  logic [20:0] len,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic [20:0] adr,
  output logic        read,
  input  logic [7:0]  din,
  output logic        tx
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP, S_CSUM, S_FIN
  } state_t;

  localparam logic [9:0] BAUD_LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAT_LAST  = 3'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [20:0] adr_q, adr_d;
  logic [20:0] rem_q, rem_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [9:0]  baud_q, baud_d;
  logic [2:0]  lat_q, lat_d;
  logic        csum_q, csum_d;   // current frame is the checksum frame
  logic        pend_q, pend_d;   // start accepted while hold was high
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        read_q, read_d;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    lat_d   = lat_q;
    csum_d  = csum_q;
    pend_d  = pend_q;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          if (!hold) begin
            pend_d  = 1'b0;
            state_d = S_FETCH;
          end
        end else if (start) begin
          adr_d  = start_adr;
          rem_d  = len;
          sum_d  = 8'h00;
          csum_d = 1'b0;
          if (hold) begin
            pend_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        lat_d   = 3'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          shift_d = din;
          sum_d   = sum_q + din;
          baud_d  = 10'd0;
          state_d = S_START;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d  = 10'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 10'd1;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_d = 10'd0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 10'd1;
        end
      end

      S_STOP: begin
        // At the end of the stop bit the baud counter parks at its last value,
        // so a held stop bit is simply re-evaluated every cycle.
        if (!baud_end) begin
          baud_d = baud_q + 10'd1;
        end else if (csum_q) begin
          baud_d  = 10'd0;
          state_d = S_FIN;
        end else if (!hold) begin
          baud_d = 10'd0;
          if (rem_q != 21'd0) begin
            rem_d   = rem_q - 21'd1;
            adr_d   = adr_q + 21'd1;   // wraps 0x1FFFFF -> 0x000000
            state_d = S_FETCH;
          end else begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        shift_d = sum_q;
        csum_d  = 1'b1;
        baud_d  = 10'd0;
        state_d = S_START;
      end

      S_FIN: begin
        csum_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change cleanly on
    // the edge that enters each state.
    tx_d = 1'b1;
    if (state_d == S_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_DATA) begin
      tx_d = shift_d[0];
    end
    read_d = (state_d == S_FETCH);
    busy_d = (state_d != S_IDLE) || pend_d;
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      adr_q   <= 21'd0;
      rem_q   <= 21'd0;
      sum_q   <= 8'h00;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      baud_q  <= 10'd0;
      lat_q   <= 3'd0;
      csum_q  <= 1'b0;
      pend_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      lat_q   <= lat_d;
      csum_q  <= csum_d;
      pend_q  <= pend_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      read_q  <= read_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign read = read_q;
  assign adr  = adr_q;

endmodule

// File: tb/tb_mem_dump_uart.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_uart
//
// Directed bench for mem_dump_uart with CLKS_PER_BIT=4, RD_LAT=1. A memory
// model answers reads one cycle later; a monitor logs reads, done pulses and
// decodes tx frames sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_dump_uart;

  logic        clk;
  logic        n_reset;
  logic        start;
  logic [20:0] start_adr;
  logic [20:0] len;
  logic        hold;
  logic        busy;
  logic        done;
  logic [20:0] adr;
  logic        read;
  logic [7:0]  din;
  logic        tx;

  mem_dump_uart #(.CLKS_PER_BIT(4), .RD_LAT(1)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (start),
    .start_adr (start_adr),
    .len       (len),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .adr       (adr),
    .read      (read),
    .din       (din),
    .tx        (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model and monitor ----------------
  logic [7:0] mem [logic [20:0]];

  function automatic logic [7:0] mem_rd(input logic [20:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Expected 40-sample waveform of one 8N1 frame at 4 samples per bit.
  function automatic logic [39:0] frame_vec(input logic [7:0] b);
    logic [39:0] v;
    for (int t = 0; t < 40; t++) begin
      if (t < 4)       v[t] = 1'b0;
      else if (t < 36) v[t] = b[(t - 4) / 4];
      else             v[t] = 1'b1;
    end
    return v;
  endfunction

  int          cyc = 0;
  logic        rd_seen = 1'b0;
  logic [7:0]  din_pipe = 8'h00;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [20:0] rd_adr [$];
  int          rd_cyc [$];
  logic [7:0]  fr_data [$];
  logic [39:0] fr_vec [$];
  int          fr_start [$];

  initial begin
    logic        rx_act;
    int          rx_t;
    logic [39:0] rx_vec;
    logic [7:0]  d;
    rx_act = 1'b0;
    rx_t   = 0;
    rx_vec = '1;
    forever begin
      @(negedge clk);
      cyc++;
      rd_seen  = read;
      din_pipe = mem_rd(adr);
      if (read) begin
        rd_adr.push_back(adr);
        rd_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!n_reset) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (!tx) begin
          rx_act    = 1'b1;
          rx_t      = 0;
          rx_vec    = '1;
          rx_vec[0] = 1'b0;
          fr_start.push_back(cyc);
        end
      end else begin
        rx_t++;
        rx_vec[rx_t] = tx;
        if (rx_t == 39) begin
          for (int i = 0; i < 8; i++) d[i] = rx_vec[4 * (i + 1) + 2];
          fr_data.push_back(d);
          fr_vec.push_back(rx_vec);
          rx_act = 1'b0;
        end
      end
    end
  end

  // Read data appears one cycle after the read strobe, garbage otherwise.
  initial begin
    din = 8'hEE;
    forever begin
      @(posedge clk);
      din <= rd_seen ? din_pipe : 8'hEE;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_log();
    rd_adr.delete();
    rd_cyc.delete();
    fr_data.delete();
    fr_vec.delete();
    fr_start.delete();
    done_cnt = 0;
  endtask

  task automatic start_dump(input logic [20:0] a, input logic [20:0] l, output int k);
    @(posedge clk);
    #1;
    start_adr = a;
    len       = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    k     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base;
    base = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == base; i++) @(negedge clk);
    check({tag, "_done_seen"}, 64'(done_cnt > base), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frame_start(input string tag);
    for (int i = 0; i < 200 && fr_start.size() == 0; i++) @(negedge clk);
    check({tag, "_frame_started"}, 64'(fr_start.size() > 0), 64'd1);
  endtask

  task automatic report(input string tag);
    $display("dump %s: reads=%0d frames=%0d done=%0d", tag, rd_adr.size(), fr_data.size(), done_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int m;
    int lows;
    int nrd;
    int nfr;

    n_reset   = 1'b0;
    start     = 1'b0;
    start_adr = 21'd0;
    len       = 21'd0;
    hold      = 1'b0;

    mem[21'h00100] = 8'hA5;
    mem[21'h1FFFFE] = 8'h01;
    mem[21'h1FFFFF] = 8'h02;
    mem[21'h00000] = 8'hFF;
    mem[21'h00300] = 8'h55;
    mem[21'h00400] = 8'h11;
    mem[21'h00401] = 8'h22;
    mem[21'h00500] = 8'h0A;
    mem[21'h00501] = 8'h0B;
    mem[21'h00200] = 8'h77;
    mem[21'h00600] = 8'h3C;
    mem[21'h00601] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_read", 64'(read), 64'd0);
    check("rst_adr", 64'(adr), 64'd0);
    n_reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1. single byte
    clear_log();
    start_dump(21'h00100, 21'd0, k);
    wait_done("single");
    report("single");
    check("single_nreads", 64'(rd_adr.size()), 64'd1);
    check("single_rd_adr", 64'(rd_adr[0]), 64'h00100);
    check("single_rd_cyc", 64'(rd_cyc[0]), 64'(k + 1));
    check("single_nframes", 64'(fr_data.size()), 64'd2);
    check("single_data", 64'(fr_data[0]), 64'hA5);
    check("single_csum", 64'(fr_data[1]), 64'hA5);
    check("single_ndone", 64'(done_cnt), 64'd1);
    check("single_done_cyc", 64'(done_cyc), 64'(k + 84));
    check("single_busy_low", 64'(busy), 64'd0);

    // 2. address wrap
    clear_log();
    start_dump(21'h1FFFFE, 21'd2, k);
    wait_done("wrap");
    report("wrap");
    check("wrap_nreads", 64'(rd_adr.size()), 64'd3);
    check("wrap_rd0", 64'(rd_adr[0]), 64'h1FFFFE);
    check("wrap_rd1", 64'(rd_adr[1]), 64'h1FFFFF);
    check("wrap_rd2", 64'(rd_adr[2]), 64'h000000);
    check("wrap_nframes", 64'(fr_data.size()), 64'd4);
    check("wrap_f0", 64'(fr_data[0]), 64'h01);
    check("wrap_f1", 64'(fr_data[1]), 64'h02);
    check("wrap_f2", 64'(fr_data[2]), 64'hFF);
    check("wrap_csum", 64'(fr_data[3]), 64'h02);
    check("wrap_gap", 64'(fr_start[1] - fr_start[0]), 64'd42);
    check("wrap_ndone", 64'(done_cnt), 64'd1);

    // 3. bit timing with 0x55
    clear_log();
    start_dump(21'h00300, 21'd0, k);
    wait_done("timing");
    report("timing");
    check("timing_tx_fall", 64'(fr_start[0]), 64'(k + 3));
    check("timing_wave", 64'(fr_vec[0]), 64'(frame_vec(8'h55)));
    check("timing_csum_start", 64'(fr_start[1] - fr_start[0]), 64'd41);
    check("timing_csum_wave", 64'(fr_vec[1]), 64'(frame_vec(8'h55)));

    // 4. flow control
    clear_log();
    start_dump(21'h00400, 21'd1, k);
    wait_frame_start("flow");
    repeat (10) @(posedge clk);
    #1;
    hold = 1'b1;
    repeat (40) @(posedge clk);
    lows = 0;
    nrd  = rd_adr.size();
    nfr  = fr_data.size();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("flow_held_reads", 64'(rd_adr.size()), 64'(nrd));
    check("flow_held_nreads", 64'(nrd), 64'd1);
    check("flow_held_tx_low", 64'(lows), 64'd0);
    check("flow_held_frames", 64'(fr_data.size()), 64'(nfr));
    @(posedge clk);
    #1;
    hold = 1'b0;
    m = cyc;
    wait_done("flow");
    report("flow");
    check("flow_rd1_adr", 64'(rd_adr[1]), 64'h00401);
    check("flow_rd1_cyc", 64'(rd_cyc[1]), 64'(m + 2));
    check("flow_f0", 64'(fr_data[0]), 64'h11);
    check("flow_f1", 64'(fr_data[1]), 64'h22);
    check("flow_csum", 64'(fr_data[2]), 64'h33);

    // 5. start while busy
    clear_log();
    start_dump(21'h00500, 21'd1, k);
    repeat (20) @(posedge clk);
    #1;
    start_adr = 21'h00200;
    len       = 21'd0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start");
    repeat (20) @(negedge clk);
    report("busy_start");
    check("bstart_nreads", 64'(rd_adr.size()), 64'd2);
    check("bstart_rd0", 64'(rd_adr[0]), 64'h00500);
    check("bstart_rd1", 64'(rd_adr[1]), 64'h00501);
    check("bstart_nframes", 64'(fr_data.size()), 64'd3);
    check("bstart_csum", 64'(fr_data[2]), 64'h15);
    check("bstart_ndone", 64'(done_cnt), 64'd1);

    // 6. reset in the middle of a data bit
    clear_log();
    start_dump(21'h00600, 21'd1, k);
    wait_frame_start("reset");
    repeat (12) @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check("arst_tx", 64'(tx), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_read", 64'(read), 64'd0);
    check("arst_adr", 64'(adr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (2) @(posedge clk);
    clear_log();
    start_dump(21'h00100, 21'd0, k);
    wait_done("after_reset");
    report("after_reset");
    check("arst_nreads", 64'(rd_adr.size()), 64'd1);
    check("arst_rd_adr", 64'(rd_adr[0]), 64'h00100);
    check("arst_data", 64'(fr_data[0]), 64'hA5);
    check("arst_csum", 64'(fr_data[1]), 64'hA5);
    check("arst_ndone", 64'(done_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
